// File: rtl/wallace.sv
// Unsigned 4x4 multiplier: Wallace-tree reduction of the AND partial products,
// a ripple carry-propagate adder, and one output register.

module ha (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module fa (
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i ^ z_i;
  assign c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
endmodule

module wallace (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // pp[i][j] = a[j] & b[i], column weight i+j
  logic [3:0] pp [4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = a & {4{b[i]}};
    end
  end

  // Stage 1 heights (col0..6): 1,2,3,4,3,2,1
  logic s1_1, c1_1, s1_2, c1_2, s1_3, c1_3, s1_4, c1_4, s1_5, c1_5;

  ha h1_1 (.x_i(pp[0][1]), .y_i(pp[1][0]), .s_o(s1_1), .c_o(c1_1));
  fa f1_2 (.x_i(pp[0][2]), .y_i(pp[1][1]), .z_i(pp[2][0]), .s_o(s1_2), .c_o(c1_2));
  fa f1_3 (.x_i(pp[0][3]), .y_i(pp[1][2]), .z_i(pp[2][1]), .s_o(s1_3), .c_o(c1_3));
  fa f1_4 (.x_i(pp[1][3]), .y_i(pp[2][2]), .z_i(pp[3][1]), .s_o(s1_4), .c_o(c1_4));
  ha h1_5 (.x_i(pp[2][3]), .y_i(pp[3][2]), .s_o(s1_5), .c_o(c1_5));

  // Stage 2 heights (col0..6): 1,1,2,3,2,2,2 ; pp[3][0] is column 3's leftover bit
  logic s2_2, c2_2, s2_3, c2_3, s2_4, c2_4, s2_5, c2_5, s2_6, c2_6;

  ha h2_2 (.x_i(s1_2), .y_i(c1_1), .s_o(s2_2), .c_o(c2_2));
  fa f2_3 (.x_i(s1_3), .y_i(pp[3][0]), .z_i(c1_2), .s_o(s2_3), .c_o(c2_3));
  ha h2_4 (.x_i(s1_4), .y_i(c1_3), .s_o(s2_4), .c_o(c2_4));
  ha h2_5 (.x_i(s1_5), .y_i(c1_4), .s_o(s2_5), .c_o(c2_5));
  ha h2_6 (.x_i(pp[3][3]), .y_i(c1_5), .s_o(s2_6), .c_o(c2_6));

  // Final ripple over columns 3..7; every column now holds at most two bits
  logic [7:0] prod_d;
  logic k3, k4, k5, k6, co7_unused;

  assign prod_d[0] = pp[0][0];
  assign prod_d[1] = s1_1;
  assign prod_d[2] = s2_2;

  ha r3 (.x_i(s2_3), .y_i(c2_2), .s_o(prod_d[3]), .c_o(k3));
  fa r4 (.x_i(s2_4), .y_i(c2_3), .z_i(k3), .s_o(prod_d[4]), .c_o(k4));
  fa r5 (.x_i(s2_5), .y_i(c2_4), .z_i(k4), .s_o(prod_d[5]), .c_o(k5));
  fa r6 (.x_i(s2_6), .y_i(c2_5), .z_i(k5), .s_o(prod_d[6]), .c_o(k6));
  // 15*15 = 225 fits in 8 bits, so the column-7 carry is always 0
  ha r7 (.x_i(c2_6), .y_i(k6), .s_o(prod_d[7]), .c_o(co7_unused));

  logic [7:0] p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= 8'h00;
    end else begin
      p_q <= prod_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_wallace.sv
// Bench for the wallace multiplier: a driver pushes expected products into a
// queue, a monitor pops and compares one per clock after each rising edge.

module tb_wallace;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] p;

  logic [7:0] exp_q[$];
  int         total;
  int         bad;

  wallace dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .p   (p)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst   = 1'b1;
    a     = 4'h0;
    b     = 4'h0;
    total = 0;
    bad   = 0;
  end

  // Driver: inputs change on the falling edge, one expected product per cycle
  task automatic drive(input logic r, input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] e);
    @(negedge clk);
    rst = r;
    a   = x;
    b   = y;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        total++;
        if (p !== exp_v) begin
          bad++;
          $display("FAIL product: a=%0d b=%0d rst=%0b got p=%h expected %h at t=%0t",
                   a, b, rst, p, exp_v, $time);
        end
      end
    end
  end

  // Directed vectors with hand-computed products
  typedef struct {
    logic       r;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] e;
  } vec_t;

  vec_t dir_v[14];

  initial begin
    dir_v[0]  = '{1'b1, 4'hF, 4'hF, 8'h00};  // reset held, max operands
    dir_v[1]  = '{1'b1, 4'hF, 4'hF, 8'h00};
    dir_v[2]  = '{1'b0, 4'hB, 4'hF, 8'hA5};  // 11*15=165
    dir_v[3]  = '{1'b0, 4'hF, 4'hF, 8'hE1};  // 225
    dir_v[4]  = '{1'b0, 4'hD, 4'hB, 8'h8F};  // 13*11=143
    dir_v[5]  = '{1'b0, 4'h0, 4'h9, 8'h00};
    dir_v[6]  = '{1'b0, 4'h7, 4'h1, 8'h07};
    dir_v[7]  = '{1'b0, 4'h8, 4'h8, 8'h40};
    dir_v[8]  = '{1'b0, 4'h1, 4'hC, 8'h0C};  // a=1 passes b
    dir_v[9]  = '{1'b0, 4'h9, 4'h0, 8'h00};
    dir_v[10] = '{1'b0, 4'h6, 4'h5, 8'h1E};  // 30
    dir_v[11] = '{1'b1, 4'hE, 4'hE, 8'h00};  // reset beats capture
    dir_v[12] = '{1'b0, 4'hE, 4'hE, 8'hC4};  // 196
    dir_v[13] = '{1'b0, 4'hA, 4'h3, 8'h1E};  // 30
  end

  // Stimulus sequence and final report
  initial begin
    logic [7:0] ref_p;
    #1;
    for (int k = 0; k < 14; k++) begin
      drive(dir_v[k].r, dir_v[k].x, dir_v[k].y, dir_v[k].e);
    end

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (i == 9 && j == 3) begin
          drive(1'b1, 4'(i), 4'(j), 8'h00);
        end
        ref_p = 8'(i * j);
        drive(1'b0, 4'(i), 4'(j), ref_p);
      end
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
